// File: rtl/addsub_pkg.sv
// Shared op-code constants for the add/subtract stream datapath.
package addsub_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDS = 2'b10;
    localparam logic [1:0] OP_SUBS = 2'b11;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; reads data at the head, zeroed when empty.
module sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop     = rd_en && !empty;
    // A write into a full FIFO is legal only when the head leaves in the same cycle.
    assign push    = wr_en && (!full || pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/addsub_stream.sv
// Streaming add/subtract unit: one compute stage register feeding a result FIFO.
module addsub_stream
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_carry,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH:0]   raw;
    logic             is_sub;
    logic             is_sat;
    logic [WIDTH-1:0] calc_result;
    logic             calc_carry;
    logic             calc_ovf;

    logic             stage_valid;
    logic [WIDTH+1:0] stage_data;
    logic [WIDTH+1:0] head_data;
    logic [CW:0]      occupancy;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             pop;
    logic             fifo_wr;

    // Carry/borrow fall out of the extra MSB; saturation clamps toward the sign of a.
    always_comb begin
        sum_ext  = {1'b0, in_a} + {1'b0, in_b};
        diff_ext = {1'b0, in_a} - {1'b0, in_b};
        is_sub   = (in_op == OP_SUB) || (in_op == OP_SUBS);
        is_sat   = (in_op == OP_ADDS) || (in_op == OP_SUBS);
        raw      = is_sub ? diff_ext : sum_ext;
        calc_carry  = raw[WIDTH];
        calc_result = raw[WIDTH-1:0];
        if (is_sub) begin
            calc_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (raw[WIDTH-1] != in_a[WIDTH-1]);
        end else begin
            calc_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (raw[WIDTH-1] != in_a[WIDTH-1]);
        end
        if (is_sat && calc_ovf) begin
            calc_result = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Counting the stage slot keeps in_ready free of out_ready/in_valid paths.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, stage_valid};
    assign in_ready  = (occupancy < (CW+1)'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign fifo_wr   = stage_valid && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else if (accept) begin
            stage_valid <= 1'b1;
            stage_data  <= {calc_carry, calc_ovf, calc_result};
        end else if (fifo_wr) begin
            stage_valid <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH(WIDTH + 2),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (fifo_wr),
        .wr_data(stage_data),
        .rd_en  (out_ready),
        .rd_data(head_data),
        .count  (count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign out_carry  = head_data[WIDTH+1];
    assign out_ovf    = head_data[WIDTH];
    assign out_result = head_data[WIDTH-1:0];

endmodule

// File: tb/tb_addsub_stream.sv
// Directed bench for addsub_stream: vector table plus backpressure, streaming and reset sequences.
module tb_addsub_stream;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic              out_carry;
    logic              out_ovf;
    logic [2:0]        count;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] result;
        logic        carry;
        logic        ovf;
    } vec_t;

    vec_t vecs [12];

    addsub_stream #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        in_op = op;
        in_a  = a;
        in_b  = b;
    endtask

    initial begin
        int acc;
        int nout;
        int first_cyc;
        int max_cnt;
        int gaps;
        int ready_drops;

        vecs[0]  = '{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[1]  = '{2'b10, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        vecs[2]  = '{2'b11, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
        vecs[4]  = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{2'b00, 16'h1234, 16'h0101, 16'h1335, 1'b0, 1'b0};
        vecs[6]  = '{2'b01, 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
        vecs[8]  = '{2'b11, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1};
        vecs[9]  = '{2'b10, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0};
        vecs[10] = '{2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        vecs[11] = '{2'b11, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0};

        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        applyStimulus(2'b00, 16'h0, 16'h0);
        step();
        step();
        reset = 1'b0;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_result", 32'(out_result), 32'd0);
        checkOutput("rst_carry", 32'(out_carry), 32'd0);
        checkOutput("rst_ovf", 32'(out_ovf), 32'd0);

        // Single transfers: result must appear exactly two edges after acceptance.
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            in_valid = 1'b1;
            checkOutput($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            checkOutput($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
            step();
            checkOutput($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("v%0d_result", i), 32'(out_result), 32'(vecs[i].result));
            checkOutput($sformatf("v%0d_carry", i), 32'(out_carry), 32'(vecs[i].carry));
            checkOutput($sformatf("v%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].ovf));
            step();
            checkOutput($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: exactly DEPTH accepts, then in-order drain.
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(2'b00, 16'(16'h0100 + acc), 16'h0001);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        checkOutput("bp_accepts", 32'(acc), 32'd4);
        checkOutput("bp_count", 32'(count), 32'd4);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_result%0d", k), 32'(out_result), 32'(16'h0101 + k));
            step();
        end
        checkOutput("bp_empty_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_empty_count", 32'(count), 32'd0);

        // Streaming: 16 back-to-back adds, results on consecutive cycles.
        nout = 0;
        first_cyc = -1;
        max_cnt = 0;
        gaps = 0;
        ready_drops = 0;
        for (int c = 0; c < 24; c++) begin
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = c;
                if (c != first_cyc + nout) gaps++;
                checkOutput($sformatf("st_result%0d", nout), 32'(out_result), 32'(3 * nout));
                nout++;
            end
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (c < 16) begin
                applyStimulus(2'b00, 16'(c), 16'(2 * c));
                in_valid = 1'b1;
                if (!in_ready) ready_drops++;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        checkOutput("st_results", 32'(nout), 32'd16);
        checkOutput("st_gaps", 32'(gaps), 32'd0);
        checkOutput("st_ready_drops", 32'(ready_drops), 32'd0);
        checkOutput("st_max_count_le1", 32'(max_cnt <= 1), 32'd1);

        // Reset with three results queued discards everything.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(2'b00, 16'hAAAA, 16'(c));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        checkOutput("rq_count", 32'(count), 32'd3);
        reset = 1'b1;
        in_valid = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        checkOutput("rq_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rq_count0", 32'(count), 32'd0);
        checkOutput("rq_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput($sformatf("rq_stale%0d", c), 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
